uart_pixel_stream_rx: RTL and testbench

Parametrised UART-to-framebuffer receiver: 8N1 serial byte receiver, byte FIFO, and a sync-locked pixel assembler in one block. It replaces the fixed 24-bit / 40800-pixel receive path with one configurable in pixel width, frame size, FIFO depth and timeout. It adds a frame sync header, write backpressure, a timeout resync and error flags. It sits between the board `rx` pin and the frame-buffer write port.

---
 rtl/uart_pixel_stream_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_pixel_stream_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_stream_rx.sv
// UART-to-framebuffer receive path: 8N1 receiver, first-word-fall-through byte FIFO,
// and a header-locked pixel assembler that writes into a frame buffer.
//
// state   | meaning
// HUNT    | discard bytes until 0xAA
// SYNC2   | expect 0x55 to lock; a repeated 0xAA keeps waiting
// COLLECT | shift BYTES_PER_PIXEL bytes into the pixel register
// EMIT    | hold pixel_we until the sink accepts it
// DONE    | one-cycle frame_done, address rewinds
module uart_pixel_stream_rx #(
  parameter  int CLK_FREQ        = 100_000_000,
  parameter  int BAUD            = 115_200,
  parameter  int BYTES_PER_PIXEL = 3,
  parameter  int FRAME_PIXELS    = 40800,
  parameter  int FIFO_DEPTH      = 16,
  parameter  int TIMEOUT_CYCLES  = 1_000_000,
  localparam int PIX_W           = 8 * BYTES_PER_PIXEL,
  localparam int ADDR_W          = $clog2(FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              pixel_ready,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              pixel_we,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              frame_done,
  output logic              frame_error,
  output logic              overrun,
  output logic              framing_err
);
  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int BC_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(DIV - 1);
  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BYTES_PER_PIXEL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [FA_W:0]     FIFO_FULL = (FA_W + 1)'(FIFO_DEPTH);

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t        rx_state, rx_state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             tick, clr_tick, sample_bit, byte_valid, set_ferr;

  assign tick = (div_cnt == '0);

  always_comb begin
    rx_state_d = rx_state;
    clr_tick   = 1'b0;
    sample_bit = 1'b0;
    byte_valid = 1'b0;
    set_ferr   = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_sync) begin
        rx_state_d = RX_START;
        clr_tick   = 1'b1;
      end
      // Mid start bit: a line already back high was only a glitch.
      RX_START: if (tick && tick_cnt == 4'd7) begin
        clr_tick   = 1'b1;
        rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick && tick_cnt == 4'd15) begin
        sample_bit = 1'b1;
        if (bit_cnt == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (tick && tick_cnt == 4'd15) begin
        rx_state_d = RX_IDLE;
        byte_valid = rx_sync;
        set_ferr   = !rx_sync;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      div_cnt     <= DIV_LOAD;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      framing_err <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      if (clr_tick || tick) div_cnt <= DIV_LOAD;
      else                  div_cnt <= div_cnt - 1'b1;
      if (clr_tick)  tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 1'b1;
      if (clr_tick)        bit_cnt <= '0;
      else if (sample_bit) bit_cnt <= bit_cnt + 1'b1;
      if (sample_bit) rx_shift <= {rx_sync, rx_shift[7:1]};
      if (set_ferr) framing_err <= 1'b1;
    end
  end

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [FA_W-1:0] wr_ptr, rd_ptr;
  logic [FA_W:0]   fifo_cnt;
  logic [7:0]      fifo_dout;
  logic            fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push       = byte_valid && (!fifo_full || pop);
  assign fifo_dout  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (byte_valid && !push) overrun <= 1'b1;
    end
  end

  typedef enum logic [2:0] {HUNT, SYNC2, COLLECT, EMIT, DONE} asm_state_t;
  asm_state_t      state, state_d;
  logic [BC_W-1:0] byte_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic            start_frame, shift_byte, addr_inc, abort, timed_out, counting;

  assign timed_out = (idle_cnt == '0);
  assign counting  = (state == SYNC2) || (state == COLLECT);

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    start_frame = 1'b0;
    shift_byte  = 1'b0;
    addr_inc    = 1'b0;
    abort       = 1'b0;
    case (state)
      HUNT: if (!fifo_empty) begin
        pop = 1'b1;
        if (fifo_dout == 8'hAA) state_d = SYNC2;
      end
      SYNC2: if (!fifo_empty) begin
        pop = 1'b1;
        if (fifo_dout == 8'h55) begin
          state_d     = COLLECT;
          start_frame = 1'b1;
        end else if (fifo_dout != 8'hAA) begin
          state_d = HUNT;
        end
      end else if (timed_out) begin
        state_d = HUNT;
        abort   = 1'b1;
      end
      COLLECT: if (!fifo_empty) begin
        pop        = 1'b1;
        shift_byte = 1'b1;
        if (byte_cnt == BC_LAST) state_d = EMIT;
      end else if (timed_out) begin
        state_d = HUNT;
        abort   = 1'b1;
      end
      EMIT: if (pixel_ready) begin
        if (pixel_addr == ADDR_LAST) begin
          state_d = DONE;
        end else begin
          state_d  = COLLECT;
          addr_inc = 1'b1;
        end
      end
      DONE:    state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  assign pixel_we    = (state == EMIT);
  assign frame_done  = (state == DONE);
  assign frame_error = abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      pixel_data <= '0;
      pixel_addr <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= TO_LOAD;
    end else begin
      state <= state_d;
      if (start_frame || abort || state == DONE) pixel_addr <= '0;
      else if (addr_inc)                         pixel_addr <= pixel_addr + 1'b1;
      if (start_frame || abort) byte_cnt <= '0;
      else if (shift_byte)      byte_cnt <= (byte_cnt == BC_LAST) ? '0 : byte_cnt + 1'b1;
      // First byte of a pixel ends up in the MSBs.
      if (abort)           pixel_data <= '0;
      else if (shift_byte) pixel_data <= (pixel_data << 8) | PIX_W'(fifo_dout);
      if (pop || !counting) idle_cnt <= TO_LOAD;
      else if (!timed_out)  idle_cnt <= idle_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_pixel_stream_rx.sv
// Bench for uart_pixel_stream_rx: serial byte driver, queue-based pixel model with a
// per-cycle write-port checker, and directed frame / sync / stall / timeout / reset scenarios.
module tb_uart_pixel_stream_rx;
  localparam int BPP      = 3;
  localparam int FP       = 4;
  localparam int PW       = 8 * BPP;
  localparam int AW       = 2;
  localparam int BIT_CLKS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1, rx2 = 1'b1;
  logic pixel_ready = 1'b1, ready2 = 1'b0;
  logic [PW-1:0] pixel_data, pd2;
  logic [AW-1:0] pixel_addr, addr2;
  logic pixel_we, frame_done, frame_error, overrun, framing_err;
  logic we2, done2, err2, ovr2, ferr2;

  always #5 clk = ~clk;

  uart_pixel_stream_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .BYTES_PER_PIXEL(BPP),
    .FRAME_PIXELS(FP), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .pixel_ready(pixel_ready),
    .pixel_data(pixel_data), .pixel_we(pixel_we), .pixel_addr(pixel_addr),
    .frame_done(frame_done), .frame_error(frame_error),
    .overrun(overrun), .framing_err(framing_err)
  );

  uart_pixel_stream_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .BYTES_PER_PIXEL(BPP),
    .FRAME_PIXELS(FP), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(200)
  ) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .pixel_ready(ready2),
    .pixel_data(pd2), .pixel_we(we2), .pixel_addr(addr2),
    .frame_done(done2), .frame_error(err2),
    .overrun(ovr2), .framing_err(ferr2)
  );

  int n_tests = 0, n_fail = 0;
  int n_writes = 0, n_done = 0, n_err = 0, stall_cycles = 0;
  logic [PW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [PW-1:0] log_data[64];
  logic [AW-1:0] log_addr[64];
  logic [7:0]    pay[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Model: each BPP-byte group after the header is one pixel, first byte in the MSBs.
  task automatic expect_pay(input int skip);
    logic [PW-1:0] d;
    for (int p = 0; p < (pay.size() - skip) / BPP; p++) begin
      d = '0;
      for (int k = 0; k < BPP; k++) d = (d << 8) | PW'(pay[skip + p * BPP + k]);
      exp_data.push_back(d);
      exp_addr.push_back(AW'(p));
    end
  endtask

  task automatic send_byte(input int line, input logic [7:0] b, input logic stop);
    logic [9:0] frm;
    frm = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (line == 1) rx = frm[i]; else rx2 = frm[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    if (line == 1) rx = 1'b1; else rx2 = 1'b1;
    if (!stop) repeat (2 * BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_pay(input int line);
    for (int i = 0; i < pay.size(); i++) send_byte(line, pay[i], 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_data.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, exp_data.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  logic prev_we = 1'b0, prev_ready = 1'b0, prev_xfer = 1'b0, prev_final = 1'b0;
  logic [PW-1:0] prev_data, ed;
  logic [AW-1:0] prev_addr, ea;

  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0; prev_xfer = 1'b0; prev_final = 1'b0;
    end else begin
      check("frame_done_timing", frame_done, prev_final);
      if (frame_done || frame_error) check("done_err_exclusive", frame_done & frame_error, 0);
      if (prev_we && !prev_ready) begin
        check("hold_we", pixel_we, 1);
        check("hold_data", pixel_data, prev_data);
        check("hold_addr", pixel_addr, prev_addr);
      end
      if (prev_xfer) check("we_drop_after_xfer", pixel_we, 0);
      prev_xfer = pixel_we && pixel_ready;
      prev_final = 1'b0;
      if (prev_xfer) begin
        if (exp_data.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr %0d data %h, no write required", pixel_addr, pixel_data);
        end else begin
          ed = exp_data.pop_front();
          ea = exp_addr.pop_front();
          check("wr_data", pixel_data, ed);
          check("wr_addr", pixel_addr, ea);
          prev_final = (ea == AW'(FP - 1));
        end
        if (n_writes < 64) begin
          log_data[n_writes] = pixel_data;
          log_addr[n_writes] = pixel_addr;
        end
        n_writes++;
      end
      if (pixel_we && !pixel_ready) stall_cycles++;
      if (frame_done) n_done++;
      if (frame_error) n_err++;
      prev_we = pixel_we; prev_ready = pixel_ready;
      prev_data = pixel_data; prev_addr = pixel_addr;
    end
  end

  int base_w, base_d, base_e, s0, t;

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_data", pixel_data, 0);
    check("rst_we", pixel_we, 0);
    check("rst_addr", pixel_addr, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_error, 0);
    check("rst_ovr", overrun, 0);
    check("rst_ferr", framing_err, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Overrun / framing on the 4-deep instance with its sink stalled.
    pay = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_pay(2);
    repeat (4) @(negedge clk);
    check("ovr_not_yet", ovr2, 0);
    check("ovr_stalled_we", we2, 1);
    check("ovr_stalled_data", pd2, 24'h010203);
    send_byte(2, 8'h08, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_set", ovr2, 1);
    check("ferr_not_yet", ferr2, 0);
    send_byte(2, 8'h5A, 1'b0);
    check("ferr_set", ferr2, 1);
    repeat (100) @(negedge clk);
    check("ovr_sticky", ovr2, 1);
    check("ferr_sticky", ferr2, 1);

    // Basic frame.
    pay = '{8'hAA, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
            8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    base_w = n_writes; base_d = n_done;
    expect_pay(2);
    send_pay(1);
    wait_drain("basic");
    check("basic_writes", n_writes - base_w, 4);
    check("basic_done", n_done - base_d, 1);
    check("basic_px0", log_data[base_w], 24'h112233);
    check("basic_px1", log_data[base_w + 1], 24'h445566);
    check("basic_px2", log_data[base_w + 2], 24'h778899);
    check("basic_px3", log_data[base_w + 3], 24'hAABBCC);
    check("basic_addr3", log_addr[base_w + 3], 3);

    // Sync robustness, header bytes inside pixel data are plain data.
    pay = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    base_w = n_writes; base_d = n_done;
    expect_pay(4);
    send_pay(1);
    wait_drain("sync");
    check("sync_writes", n_writes - base_w, 4);
    check("sync_done", n_done - base_d, 1);
    check("sync_px0", log_data[base_w], 24'hAA55AA);
    check("sync_px1", log_data[base_w + 1], 24'h550102);
    pay = '{8'hAA, 8'h12, 8'h55};
    base_w = n_writes;
    send_pay(1);
    repeat (400) @(negedge clk);
    check("badhdr_no_writes", n_writes - base_w, 0);

    // Backpressure on the addr-1 pixel.
    pay = '{8'hAA, 8'h55, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
            8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C};
    base_w = n_writes; base_d = n_done;
    expect_pay(2);
    fork
      send_pay(1);
      begin
        t = 0;
        while (n_writes < base_w + 1 && t < 5000) begin @(negedge clk); t++; end
        @(posedge clk); #1 pixel_ready = 1'b0;
        s0 = stall_cycles;
        t = 0;
        while (!pixel_we && t < 2000) begin @(negedge clk); t++; end
        check("bp_we_seen", pixel_we, 1);
        check("bp_addr", pixel_addr, 1);
        check("bp_data", pixel_data, 24'h242526);
        repeat (40) @(posedge clk);
        #1 pixel_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_stall_len", stall_cycles - s0, 40);
      end
    join
    wait_drain("bp");
    check("bp_writes", n_writes - base_w, 4);
    check("bp_done", n_done - base_d, 1);
    check("bp_px3", log_data[base_w + 3], 24'h2A2B2C);

    // Timeout mid-frame, then a clean frame.
    pay = '{8'hAA, 8'h55, 8'h31, 8'h32, 8'h33, 8'h34};
    base_w = n_writes; base_d = n_done; base_e = n_err;
    expect_pay(2);
    send_pay(1);
    t = 0;
    while (n_err == base_e && t < 1000) begin @(negedge clk); t++; end
    repeat (50) @(negedge clk);
    check("to_err_once", n_err - base_e, 1);
    check("to_no_done", n_done - base_d, 0);
    check("to_partial_px0", log_data[base_w], 24'h313233);
    pay = '{8'hAA, 8'h55, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
            8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C};
    base_w = n_writes; base_d = n_done;
    expect_pay(2);
    send_pay(1);
    wait_drain("to_resync");
    check("to_resync_writes", n_writes - base_w, 4);
    check("to_resync_px0", log_data[base_w], 24'h414243);
    check("to_resync_addr0", log_addr[base_w], 0);
    check("to_resync_done", n_done - base_d, 1);

    // A header byte with a bad stop bit must not be pushed.
    base_w = n_writes;
    send_byte(1, 8'hAA, 1'b0);
    pay = '{8'h55, 8'h01, 8'h02, 8'h03};
    send_pay(1);
    repeat (300) @(negedge clk);
    check("ferr1_set", framing_err, 1);
    check("ferr1_no_writes", n_writes - base_w, 0);
    check("ferr1_no_ovr", overrun, 0);

    // Async reset after pixel 1.
    pay = '{8'hAA, 8'h55, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
    base_w = n_writes;
    expect_pay(2);
    send_pay(1);
    t = 0;
    while (n_writes < base_w + 2 && t < 1000) begin @(negedge clk); t++; end
    check("rr_pre_writes", n_writes - base_w, 2);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("rr_data", pixel_data, 0);
    check("rr_we", pixel_we, 0);
    check("rr_addr", pixel_addr, 0);
    check("rr_done", frame_done, 0);
    check("rr_err", frame_error, 0);
    check("rr_ovr", overrun, 0);
    check("rr_ferr", framing_err, 0);
    check("rr_ovr2", ovr2, 0);
    check("rr_ferr2", ferr2, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    pay = '{8'hAA, 8'h55, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
            8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C};
    base_w = n_writes; base_d = n_done;
    expect_pay(2);
    send_pay(1);
    wait_drain("rr_fresh");
    check("rr_fresh_writes", n_writes - base_w, 4);
    check("rr_fresh_done", n_done - base_d, 1);
    check("rr_fresh_px0", log_data[base_w], 24'h616263);
    check("rr_fresh_px3", log_data[base_w + 3], 24'h6A6B6C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
